uart_tx_sequencer: RTL and testbench

Frame sequencer for the UART transmit path. It takes one data word per valid/ready handshake and serialises it onto the `tx` line as a start bit, data bits (LSB first), an optional parity bit and stop bits. Bit boundaries come from the single-cycle `baud_tick` enable produced by the baud rate generator, which pulses once every CLKS_PER_BIT system clocks. It sits between the BNN result/readout logic and the chip's UART TX pin.

---
 rtl/uart_tx_sequencer.sv | 138 +++++++++++++
 tb/tb_uart_tx_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// Serialises one word per valid/ready handshake onto the UART tx line as
// start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop
// bits. Bit boundaries are taken from the single-cycle baud_tick enable.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   baud_tick   one-cycle bit-period enable
//   tx_data     word to send, sampled on accept
//   tx_valid    requester has a word
//   tx_ready    sequencer can accept (state == IDLE)
//   tx          registered serial line, idle high
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse after the last stop bit
//
// state  | meaning
// IDLE   | line high, ready for a word
// SYNC   | word latched, waiting for the next tick to align the start bit
// START  | start bit (low) on the line
// DATA   | data bit shift_q[0] on the line, idx_q counts bits sent
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line, stop_q counts them
module uart_tx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       ODD       = (PARITY_ODD != 0);

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           idx_q;
  logic                 stop_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          // A tick in this same cycle is deliberately ignored; SYNC waits
          // for the next one so the start bit is always a full period.
          if (tx_valid) begin
            shift_q  <= tx_data;
            parity_q <= (^tx_data) ^ ODD;
            state_q  <= SYNC;
          end
        end
        SYNC: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (idx_q != LAST_IDX) begin
              // tx takes the bit that becomes shift_q[0] after this shift
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[1];
            end else if (PARITY_EN != 0) begin
              tx_q    <= parity_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
              state_q <= STOP;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= STOP;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_tick) begin
            if (stop_q != LAST_STOP) begin
              stop_q <= 1'b1;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: four instances (8N1, 8E1, 8O1, 5N2) share
// clock, reset and baud_tick. A timeline model predicts the line level,
// busy, tx_ready and frame_done of every instance in every cycle.
module tb_uart_tx_sequencer;

  localparam int P = 8;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [7:0] td   [4];
  logic       tv   [4];
  logic       rdy  [4];
  logic       txo  [4];
  logic       bsy  [4];
  logic       done [4];

  int db_c [4] = '{8, 8, 8, 5};
  int pe_c [4] = '{0, 1, 1, 0};
  int po_c [4] = '{0, 0, 1, 0};
  int sb_c [4] = '{1, 1, 1, 2};

  uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[0]), .tx_valid(tv[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(done[0]));
  uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[1]), .tx_valid(tv[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(done[1]));
  uart_tx_sequencer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[2]), .tx_valid(tv[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(done[2]));
  uart_tx_sequencer #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(td[3][4:0]), .tx_valid(tv[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .frame_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int tick_div = 0;

  // timeline model: after tick k (1..len) the line shows bit k-1 of the
  // frame; tick len+1 ends the frame
  bit          m_act  [4];
  int          m_tk   [4];
  int          m_len  [4];
  int          m_acc  [4];
  logic [11:0] m_bits [4];
  logic        e_tx   [4];
  logic        e_done [4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [11:0] frame_of(int i, logic [7:0] w);
    logic [11:0] b;
    int ones;
    int k;
    b = '1;
    ones = 0;
    b[0] = 1'b0;
    k = 1;
    for (int j = 0; j < db_c[i]; j++) begin
      b[k] = w[j];
      if (w[j]) ones++;
      k++;
    end
    if (pe_c[i] != 0) b[k] = ((ones % 2) == 1) ^ (po_c[i] != 0);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst) begin
        m_act[i] = 0; e_tx[i] = 1'b1; e_done[i] = 1'b0;
      end else begin
        e_done[i] = 1'b0;
        if (!m_act[i]) begin
          e_tx[i] = 1'b1;
          if (tv[i]) begin
            m_bits[i] = frame_of(i, td[i]);
            m_len[i]  = 1 + db_c[i] + pe_c[i] + sb_c[i];
            m_tk[i]   = 0;
            m_act[i]  = 1;
            m_acc[i]++;
          end
        end else if (baud_tick) begin
          m_tk[i]++;
          if (m_tk[i] <= m_len[i]) e_tx[i] = m_bits[i][m_tk[i]-1];
          else begin
            m_act[i] = 0; e_tx[i] = 1'b1; e_done[i] = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tx%0d", i), 32'(txo[i]), 32'(e_tx[i]));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_act[i]));
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!m_act[i]));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(e_done[i]));
    end
    tick_div  = (tick_div == P - 1) ? 0 : tick_div + 1;
    baud_tick = (tick_div == P - 1);
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // present a word and hold valid until the model sees it accepted
  task automatic send(int i, logic [7:0] w, bit hold);
    int c0;
    int n;
    c0 = m_acc[i];
    td[i] = w;
    tv[i] = 1'b1;
    n = 0;
    while (m_acc[i] == c0 && n < 400) begin
      step();
      n++;
    end
    if (m_acc[i] == c0) chk("accept_timeout", 0, 1);
    if (!hold) tv[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while (m_act[i] && n < 400) begin
      step();
      n++;
    end
    if (m_act[i]) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    baud_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      td[i] = '0; tv[i] = 1'b0;
      m_act[i] = 0; m_tk[i] = 0; m_len[i] = 0; m_acc[i] = 0;
      m_bits[i] = '1; e_tx[i] = 1'b1; e_done[i] = 1'b0;
    end

    // reset values, then idle with ticks and no valid
    steps(3);
    rst = 1'b1;
    steps(20);

    // 8N1 0xA5
    send(0, 8'hA5, 0); wait_idle(0); steps(5);

    // parity: even 0x07, odd 0x07, even 0x00
    send(1, 8'h07, 0); wait_idle(1); steps(3);
    send(2, 8'h07, 0); wait_idle(2); steps(3);
    send(1, 8'h00, 0); wait_idle(1); steps(3);

    // 5 data bits, 2 stop bits
    send(3, 8'h1F, 0); wait_idle(3); steps(5);

    // back-to-back with valid held and data changing mid-frame
    send(0, 8'h00, 1);
    for (int k = 0; k < 30; k++) begin
      td[0] = 8'($urandom);
      step();
    end
    send(0, 8'hFF, 0);
    for (int k = 0; k < 30; k++) begin
      td[0] = 8'($urandom);
      step();
    end
    wait_idle(0); steps(5);

    // reset mid-frame during DATA, valid asserted while in reset
    send(0, 8'h3C, 0);
    n = 0;
    while (m_tk[0] < 4 && n < 100) begin step(); n++; end
    if (m_tk[0] < 4) chk("data_timeout", 0, 1);
    rst = 1'b0;
    tv[1] = 1'b1; td[1] = 8'h55;
    steps(3);
    tv[1] = 1'b0;
    rst = 1'b1;
    steps(4);
    send(0, 8'h3C, 0); wait_idle(0); steps(5);

    // valid coincident with a tick
    n = 0;
    while (!baud_tick && n < 20) begin step(); n++; end
    if (!baud_tick) chk("tick_timeout", 0, 1);
    td[0] = 8'h5A; tv[0] = 1'b1;
    step();
    tv[0] = 1'b0;
    wait_idle(0); steps(5);

    // randomized frames, sometimes with overlap across instances or a reset
    for (int r = 0; r < 40; r++) begin
      int i;
      int j;
      i = $urandom_range(0, 3);
      steps($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) begin
        j = (i + 1) % 4;
        td[j] = 8'($urandom); tv[j] = 1'b1;
        step();
        tv[j] = 1'b0;
      end
      send(i, 8'($urandom), $urandom_range(0, 1) == 1);
      tv[i] = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        steps($urandom_range(1, 60));
        rst = 1'b0;
        steps($urandom_range(1, 3));
        rst = 1'b1;
      end
      for (int k = 0; k < 4; k++) wait_idle(k);
    end
    steps(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
